pingpong_bram_feeder: RTL and testbench
=======================================

// Module: pingpong_bram_feeder
// PURPOSE
// - Double-buffered (ping-pong) input stage for the multiplier tree. Accepts IN_W-bit words into one BRAM bank
//   while the other bank streams out as SPLIT OUT_W-bit slices, so data loading and calculation overlap.
// - Adds output backpressure, a runtime frame length, and a mode-based result counter that raises done.
// PARAMETERS
// - IN_W       256   input word width; must equal SPLIT*OUT_W
// - OUT_W      128   slice width presented to the multiplier tree
// - SPLIT      2     slices per word (IN_W/OUT_W), 1..8
// - DEPTH      2048  words per bank; power of two
// - ADDR_W     11    $clog2(DEPTH)
// - RES_BASE   512   result target for mode 0; modes 1 and 2 use 2*RES_BASE; mode 3 uses 4*RES_BASE
// - RES_W      13    width of the result counter; must hold 4*RES_BASE
// PORTS
// - clk        in   1         clock
// - rst        in   1         asynchronous, active-high reset
// - frame_len  in   ADDR_W+1  words per frame, 1..DEPTH; latched when a bank accepts its first word
// - in_data    in   IN_W      input word
// - in_vld     in   1         input word valid
// - in_rdy     out  1         input ready
// - out_data   out  OUT_W     slice to the multiplier tree
// - out_vld    out  1         slice valid
// - out_rdy    in   1         downstream ready (backpressure)
// - mode       in   2         selects the result target
// - res_vld    in   1         one pulse per result from the tree
// - clr        in   1         synchronous clear of the result counter and done
// - bank_full  out  2         per-bank full flags (status)
// - done       out  1         sticky; result count has reached the target
// BEHAVIOUR
// - Reset (async): both banks empty; write bank = read bank = 0; counters = 0; out_vld = 0; done = 0;
//   bank_full = 0. in_rdy = 0 while rst is high, otherwise in_rdy = ~bank_full[wb] (combinational).
// - Write: a word is accepted on in_vld & in_rdy and written to BRAM address {wb, widx}.
//   On the first word of a bank, len[wb] <= frame_len. When widx == len[wb]-1: set bank_full[wb], widx <= 0,
//   wb <= ~wb. If the other bank is still full, in_rdy drops the next cycle.
// - Read FSM: IDLE -> RUN when bank_full[rb]. RUN issues a BRAM read of {rb, ridx} when the word register is
//   empty, or when its last slice is accepted in the same cycle. The BRAM has 1-cycle latency; its
//   rd_data_vld loads the word register and sets out_vld.
// - Slicing: out_data = word[IN_W-1-s*OUT_W -: OUT_W] for s = 0..SPLIT-1, most-significant slice first.
//   s advances only on out_vld & out_rdy.
// - Hold: while out_vld & ~out_rdy, out_data is held stable. No slice is dropped or duplicated.
// - Latency: 2 cycles from bank_full[rb] rising to the first out_vld.
// - Throughput: 1 slice/cycle sustained while out_rdy = 1, including across word and bank boundaries
//   (no bubble when the next bank is already full).
// - Bank release: when the last slice of word len[rb]-1 is accepted, clear bank_full[rb], set rb <= ~rb and
//   ridx <= 0, then go to RUN if the new bank is full, else IDLE.
// - Simultaneous release of bank X and fill completion of bank Y: both take effect; X is released, Y is full.
//   The same bank is never filled and released in one cycle.
// - frame_len changes mid-fill have no effect until the next bank starts filling. frame_len = 0 is treated as DEPTH.
// - Result counter: increments on res_vld and saturates at its target. done <= 1 when the count equals the
//   target (mode decoded every cycle). clr has priority over res_vld in the same cycle.
// - Reset asserted mid-frame: all partial frames are discarded; there is no recovery of BRAM contents.
// STRUCTURE
// - Shared package/include: mode encodings (MODE_0..MODE_3) and the result-target function
//   res_target(mode, RES_BASE).
// - Sub-module: one existing BRAM instance (simple dual-port, 1-cycle read, rd_data_vld), depth 2*DEPTH,
//   ADDR_W+1 address bits, with the bank number as the address MSB.
// - Everything else stays in this module: write counters, read FSM, word register and slice mux,
//   result counter.
// TESTING
// - Single frame (frame_len=4, out_rdy=1): words W0..W3 -> slices W0[255:128], W0[127:0], ... W3[127:0] on 8
//   consecutive cycles; first out_vld 2 cycles after bank_full[0] rises.
// - Overlap: stream 3 frames of 16 words back-to-back with in_vld=1 -> in_rdy falls only while both banks are
//   full; 96 slices out in order with no gaps.
// - Backpressure: drive out_rdy randomly (50%) over 2 frames -> the scoreboard sees identical order and count;
//   out_data is stable while stalled.
// - Boundaries: frame_len=1 and frame_len=DEPTH -> correct wrap of widx/ridx and bank toggle. frame_len
//   changed mid-fill applies only to the next bank. frame_len=0 -> DEPTH words.
// - Done: mode=0 with 512 res_vld pulses -> done rises on the 512th and stays high. mode=3 -> needs 2048.
//   clr together with res_vld -> count is 0.
// - Reset mid-frame: assert rst after 5 of 8 words -> all outputs at reset values, in_rdy=0 during rst. The
//   next full frame streams correctly from bank 0.

Source files
------------

// File: rtl/pingpong_bram_feeder_pkg.sv
// rtl/pingpong_bram_feeder_pkg.sv - shared mode encodings, read FSM states and result-target helper
package pingpong_bram_feeder_pkg;

    localparam logic [1:0] MODE_0 = 2'd0;
    localparam logic [1:0] MODE_1 = 2'd1;
    localparam logic [1:0] MODE_2 = 2'd2;
    localparam logic [1:0] MODE_3 = 2'd3;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RUN  = 1'b1
    } rd_state_t;

    function automatic int res_target(input logic [1:0] mode, input int base);
        case (mode)
            MODE_0:         return base;
            MODE_1, MODE_2: return 2 * base;
            default:        return 4 * base;
        endcase
    endfunction

endpackage

// File: rtl/pingpong_bram_feeder_bram.sv
// rtl/pingpong_bram_feeder_bram.sv - simple dual-port BRAM, 1-cycle registered read with rd_data_vld
module pingpong_bram_feeder_bram #(
    parameter int DW = 256,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_data_vld
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_data_q;
    logic          rd_vld_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_vld_q <= 1'b0;
        else     rd_vld_q <= rd_en;
    end

    assign rd_data     = rd_data_q;
    assign rd_data_vld = rd_vld_q;

endmodule

// File: rtl/pingpong_bram_feeder.sv
// rtl/pingpong_bram_feeder.sv - ping-pong BRAM input stage: fills one bank while the other streams
// out as MS-first slices, plus a mode-selected result counter with sticky done.
module pingpong_bram_feeder
    import pingpong_bram_feeder_pkg::*;
#(
    parameter int IN_W     = 256,
    parameter int OUT_W    = 128,
    parameter int SPLIT    = 2,
    parameter int DEPTH    = 2048,
    parameter int ADDR_W   = 11,
    parameter int RES_BASE = 512,
    parameter int RES_W    = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W:0]   frame_len,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_vld,
    output logic              in_rdy,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_vld,
    input  logic              out_rdy,
    input  logic [1:0]        mode,
    input  logic              res_vld,
    input  logic              clr,
    output logic [1:0]        bank_full,
    output logic              done
);

    localparam int S_W = (SPLIT > 1) ? $clog2(SPLIT) : 1;

    logic              wb_q, wb_d, rb_q, rb_d;
    logic [ADDR_W-1:0] widx_q, widx_d, ridx_q, ridx_d;
    logic [ADDR_W-1:0] len_m1_q [2];
    logic [ADDR_W-1:0] len_m1_d [2];
    logic [1:0]        bank_full_q, bank_full_d;
    logic              all_issued_q, all_issued_d;
    rd_state_t         state_q, state_d;
    logic [IN_W-1:0]   word_q, word_d;
    logic              word_vld_q, word_vld_d;
    logic [S_W-1:0]    s_q, s_d;
    logic [RES_W-1:0]  cnt_q, cnt_d, target;
    logic              done_q, done_d;

    logic              wr_en, rd_en, rd_data_vld;
    logic [ADDR_W:0]   rd_addr;
    logic [IN_W-1:0]   rd_data, cur_word, sliced;
    logic [ADDR_W-1:0] wlen_m1, nxt_ridx;
    logic              fire, last_slice, word_done, release_bank, nxt_rb, issue_ok;

    pingpong_bram_feeder_bram #(.DW(IN_W), .AW(ADDR_W + 1)) u_bram (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     ({wb_q, widx_q}),
        .wr_data     (in_data),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_data_vld (rd_data_vld)
    );

    always_comb begin
        in_rdy      = ~rst & ~bank_full_q[wb_q];
        wr_en       = in_vld & in_rdy;
        // frame_len = 0 wraps to DEPTH-1 here, i.e. a DEPTH-word frame
        wlen_m1     = (widx_q == '0) ? ADDR_W'(frame_len - {{ADDR_W{1'b0}}, 1'b1}) : len_m1_q[wb_q];
        wb_d        = wb_q;
        widx_d      = widx_q;
        len_m1_d    = len_m1_q;
        bank_full_d = bank_full_q;
        if (wr_en) begin
            if (widx_q == '0) len_m1_d[wb_q] = wlen_m1;
            if (widx_q == wlen_m1) begin
                bank_full_d[wb_q] = 1'b1;
                widx_d            = '0;
                wb_d              = ~wb_q;
            end else begin
                widx_d = widx_q + ADDR_W'(1);
            end
        end

        // The word is presented straight from the BRAM on its arrival cycle, so a read issued on
        // the last-slice handshake produces the next slice without a bubble.
        out_vld      = rd_data_vld | word_vld_q;
        cur_word     = rd_data_vld ? rd_data : word_q;
        sliced       = cur_word << (OUT_W * int'(s_q));
        out_data     = sliced[IN_W-1 -: OUT_W];
        fire         = out_vld & out_rdy;
        last_slice   = (s_q == S_W'(SPLIT - 1));
        word_done    = fire & last_slice;
        release_bank = word_done & all_issued_q;
        nxt_rb       = release_bank ? ~rb_q : rb_q;
        nxt_ridx     = release_bank ? '0 : ridx_q;
        issue_ok     = release_bank ? bank_full_q[~rb_q] : ~all_issued_q;
        rd_en        = (state_q == RD_RUN) & (~out_vld | word_done) & issue_ok;
        rd_addr      = {nxt_rb, nxt_ridx};

        word_d       = cur_word;
        word_vld_d   = out_vld & ~word_done;
        s_d          = s_q;
        if (fire) s_d = last_slice ? '0 : s_q + S_W'(1);

        rb_d         = nxt_rb;
        ridx_d       = nxt_ridx;
        all_issued_d = release_bank ? 1'b0 : all_issued_q;
        if (release_bank) bank_full_d[rb_q] = 1'b0;
        if (rd_en) begin
            ridx_d       = nxt_ridx + ADDR_W'(1);
            all_issued_d = (nxt_ridx == len_m1_q[nxt_rb]);
        end

        state_d = state_q;
        case (state_q)
            RD_IDLE: if (bank_full_q[rb_q]) state_d = RD_RUN;
            RD_RUN:  if (release_bank) state_d = bank_full_q[~rb_q] ? RD_RUN : RD_IDLE;
            default: state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        target = RES_W'(res_target(mode, RES_BASE));
        cnt_d  = cnt_q;
        done_d = done_q;
        if (clr) begin
            cnt_d  = '0;
            done_d = 1'b0;
        end else begin
            if (res_vld && cnt_q < target) cnt_d = cnt_q + RES_W'(1);
            if (cnt_d >= target) done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q         <= 1'b0;
            rb_q         <= 1'b0;
            widx_q       <= '0;
            ridx_q       <= '0;
            len_m1_q[0]  <= '0;
            len_m1_q[1]  <= '0;
            bank_full_q  <= '0;
            all_issued_q <= 1'b0;
            state_q      <= RD_IDLE;
            word_q       <= '0;
            word_vld_q   <= 1'b0;
            s_q          <= '0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
        end else begin
            wb_q         <= wb_d;
            rb_q         <= rb_d;
            widx_q       <= widx_d;
            ridx_q       <= ridx_d;
            len_m1_q     <= len_m1_d;
            bank_full_q  <= bank_full_d;
            all_issued_q <= all_issued_d;
            state_q      <= state_d;
            word_q       <= word_d;
            word_vld_q   <= word_vld_d;
            s_q          <= s_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
        end
    end

    assign bank_full = bank_full_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pingpong_bram_feeder.sv
// tb/tb_pingpong_bram_feeder.sv - self-checking bench for pingpong_bram_feeder
module tb_pingpong_bram_feeder;

    logic         clk = 1'b0;
    logic         rst;
    logic [11:0]  frame_len;
    logic [255:0] in_data;
    logic         in_vld;
    logic         in_rdy;
    logic [127:0] out_data;
    logic         out_vld;
    logic         out_rdy;
    logic [1:0]   mode;
    logic         res_vld;
    logic         clr;
    logic [1:0]   bank_full;
    logic         done;

    pingpong_bram_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .frame_len (frame_len),
        .in_data   (in_data),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .out_data  (out_data),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .mode      (mode),
        .res_vld   (res_vld),
        .clr       (clr),
        .bank_full (bank_full),
        .done      (done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int wa = 0;
    int pops = 0;
    int first_pop = -1;
    int last_pop = -1;
    int first_vld = -1;
    int bf0_rise = -1;
    int nfr = 0;
    int flen = 16;
    int res_cnt = 0;
    int pops0;
    bit chk_rdy = 0;
    bit rnd_rdy = 0;
    logic [127:0] exp_q [$];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_word();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic int tgt(input int m);
        if (m == 0) return 512;
        if (m == 3) return 2048;
        return 1024;
    endfunction

    always @(posedge clk) cyc++;

    // Reference model: every accepted word becomes two slices, MS half first; full-bank count is
    // completed input frames minus completely drained frames.
    always @(negedge clk) begin
        if (!rst) begin
            if (chk_rdy) check("in_rdy_model", in_rdy, ((wa / flen) - (pops / (2 * flen))) < 2);
            if (out_vld) begin
                if (exp_q.size() == 0) begin
                    check("out_vld_unexpected", out_vld, 1'b0);
                end else begin
                    check("out_data", out_data, exp_q[0]);
                    if (out_rdy) begin
                        void'(exp_q.pop_front());
                        pops++;
                        if (first_pop < 0) first_pop = cyc;
                        last_pop = cyc;
                    end
                end
                if (first_vld < 0) first_vld = cyc;
            end
            if (bank_full[0] && bf0_rise < 0) bf0_rise = cyc;
            if (in_vld && in_rdy) begin
                exp_q.push_back(in_data[255:128]);
                exp_q.push_back(in_data[127:0]);
                wa++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) out_rdy = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_words(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int waitc = 0;
            if (gaps && $urandom_range(0, 1) == 1) begin
                in_vld = 1'b0;
                @(posedge clk);
                #1;
            end
            in_data = rand_word();
            in_vld  = 1'b1;
            @(negedge clk);
            while (!in_rdy && waitc < 20000) begin
                @(negedge clk);
                waitc++;
            end
            if (!in_rdy) begin
                check("in_rdy_timeout", in_rdy, 1'b1);
                break;
            end
            @(posedge clk);
            #1;
        end
        in_vld = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || out_vld) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_queue", exp_q.size(), 0);
        check("drain_out_vld", out_vld, 1'b0);
        check("drain_bank_full", bank_full, 2'b00);
    endtask

    task automatic fill_check(input int words, input logic [11:0] fl);
        frame_len = fl;
        out_rdy   = 1'b0;
        send_words(words - 1, 1'b0);
        check("fill_partial", bank_full, 2'b00);
        send_words(1, 1'b0);
        check("fill_done", bank_full, 2'b01 << (nfr % 2));
        nfr++;
        out_rdy = 1'b1;
        pops0 = pops;
        drain(5 * words + 20);
        check("fill_slices", pops - pops0, 2 * words);
    endtask

    task automatic res_pulses(input int n);
        res_vld = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        res_vld = 1'b0;
        res_cnt += n;
    endtask

    task automatic done_mode(input int m);
        mode = 2'(m);
        clr  = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        res_cnt = 0;
        res_pulses(tgt(m) - 1);
        check("done_before_target", done, res_cnt >= tgt(m));
        res_pulses(1);
        check("done_at_target", done, res_cnt >= tgt(m));
        res_pulses(3);
        check("done_sticky", done, 1'b1);
    endtask

    initial begin
        rst = 1'b1; frame_len = 12'd4; in_data = '0; in_vld = 1'b0;
        out_rdy = 1'b1; mode = 2'd0; res_vld = 1'b0; clr = 1'b0;
        #1;
        check("rst_in_rdy", in_rdy, 1'b0);
        check("rst_out_vld", out_vld, 1'b0);
        check("rst_bank_full", bank_full, 2'b00);
        check("rst_done", done, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_rdy", in_rdy, 1'b1);

        // single frame, latency and back-to-back slices
        first_vld = -1; bf0_rise = -1; first_pop = -1; pops0 = pops;
        frame_len = 12'd4;
        send_words(4, 1'b0);
        nfr++;
        drain(50);
        check("latency", first_vld - bf0_rise, 2);
        check("single_contig", last_pop - first_pop, 7);
        check("single_count", pops - pops0, 8);

        // three 16-word frames back to back, full-bank model on in_rdy
        frame_len = 12'd16; flen = 16; wa = 0; pops = 0; first_pop = -1; chk_rdy = 1;
        send_words(48, 1'b0);
        nfr += 3;
        drain(300);
        chk_rdy = 0;
        check("overlap_count", pops, 96);
        check("overlap_contig", last_pop - first_pop, 95);

        // random backpressure and input gaps over two frames
        pops0 = pops; rnd_rdy = 1;
        send_words(32, 1'b1);
        nfr += 2;
        drain(2000);
        rnd_rdy = 0; out_rdy = 1'b1;
        check("bp_count", pops - pops0, 64);

        for (int k = 0; k < 3; k++) fill_check(1, 12'd1);
        fill_check(2048, 12'd2048);
        fill_check(2048, 12'd0);

        // frame_len changed mid-fill only affects the next bank
        frame_len = 12'd8; out_rdy = 1'b0; pops0 = pops;
        send_words(3, 1'b0);
        frame_len = 12'd4;
        send_words(4, 1'b0);
        check("midfill_not_full", bank_full, 2'b00);
        send_words(1, 1'b0);
        check("midfill_first_full", bank_full, 2'b01 << (nfr % 2));
        nfr++;
        send_words(4, 1'b0);
        check("midfill_both_full", bank_full, 2'b11);
        nfr++;
        out_rdy = 1'b1;
        drain(100);
        check("midfill_slices", pops - pops0, 24);

        done_mode(0);
        done_mode(3);
        done_mode(1);
        clr = 1'b1; res_vld = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0; res_vld = 1'b0; res_cnt = 0; mode = 2'd0;
        check("clr_prio_done", done, 1'b0);
        res_pulses(511);
        check("clr_prio_count", done, res_cnt >= tgt(0));
        res_pulses(1);
        check("clr_prio_hit", done, res_cnt >= tgt(0));

        // reset in the middle of a frame
        frame_len = 12'd8; out_rdy = 1'b0;
        send_words(5, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_in_rdy", in_rdy, 1'b0);
        check("midrst_out_vld", out_vld, 1'b0);
        check("midrst_bank_full", bank_full, 2'b00);
        check("midrst_done", done, 1'b0);
        exp_q.delete();
        nfr = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        fill_check(8, 12'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
